// File: rtl/ahb_lite_decoder_mux_pkg.sv
// ahb_lite_defs: shared AHB-Lite types and default slave region bases
package ahb_lite_defs;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} htrans_t;
  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} hresp_t;
  typedef enum logic [1:0] {NONE, S0, S1, DEF} dsel_t;
  typedef enum logic [1:0] {DEF_IDLE, DEF_ERR1, DEF_ERR2} def_state_t;
  localparam logic [31:0] S0_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] S1_BASE_DEF = 32'h0000_1000;
endpackage

// File: rtl/ahb_lite_decoder_mux_default_slave.sv
// ahb_lite_default_slave: two-cycle ERROR responder with saturating error counter
module ahb_lite_default_slave
  import ahb_lite_defs::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       accept_err,
  output logic       def_hready,
  output logic       def_hresp,
  output logic [7:0] err_count
);
  def_state_t state, state_nxt;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state     <= DEF_IDLE;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  always_comb begin
    state_nxt = DEF_IDLE;
    state_nxt = state == DEF_ERR1 ? DEF_ERR2 : accept_err ? DEF_ERR1 : DEF_IDLE;
  end
  assign def_hready = state != DEF_ERR1;
  assign def_hresp  = state != DEF_IDLE;
endmodule

// File: rtl/ahb_lite_decoder_mux.sv
// ahb_lite_decoder_mux: AHB-Lite address decoder and data-phase response mux
module ahb_lite_decoder_mux
  import ahb_lite_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REGION_BITS = 12,
  parameter logic [ADDR_W-1:0] S0_BASE = ADDR_W'(S0_BASE_DEF),
  parameter logic [ADDR_W-1:0] S1_BASE = ADDR_W'(S1_BASE_DEF)
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  output logic              HSEL0,
  output logic              HSEL1,
  input  logic              HREADYOUT0,
  input  logic              HREADYOUT1,
  input  logic              HRESP0,
  input  logic              HRESP1,
  input  logic [DATA_W-1:0] HRDATA0,
  input  logic [DATA_W-1:0] HRDATA1,
  output logic              HREADY,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic [7:0]        err_count
);
  dsel_t dsel;
  logic  match0, match1, accept_err, def_hready, def_hresp, unused;
  assign unused = ^{HADDR[REGION_BITS-1:0], HTRANS[0]};
  assign match0 = HADDR[ADDR_W-1:REGION_BITS] == S0_BASE[ADDR_W-1:REGION_BITS];
  assign match1 = HADDR[ADDR_W-1:REGION_BITS] == S1_BASE[ADDR_W-1:REGION_BITS];
  assign HSEL0 = match0;
  assign HSEL1 = match1 & ~match0;
  assign accept_err = HREADY & ~match0 & ~match1 & HTRANS[1];
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) dsel <= NONE;
    else if (HREADY) dsel <= HSEL0 ? S0 : HSEL1 ? S1 : HTRANS[1] ? DEF : NONE;
  assign HREADY = dsel == S0 ? HREADYOUT0 : dsel == S1 ? HREADYOUT1 : dsel == DEF ? def_hready : 1'b1;
  assign HRESP  = dsel == S0 ? HRESP0 : dsel == S1 ? HRESP1 : dsel == DEF ? def_hresp : 1'b0;
  assign HRDATA = dsel == S0 ? HRDATA0 : dsel == S1 ? HRDATA1 : '0;
  ahb_lite_default_slave u_def (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .accept_err(accept_err),
    .def_hready(def_hready),
    .def_hresp (def_hresp),
    .err_count (err_count)
  );
endmodule
